game_flow_ctrl: RTL and testbench

- Top-level game sequencer for the snake design.
- Owns the game state (idle / playing / respawn / over) and the lives count.
- Gates fruit events into the scoreboard and issues the single-cycle game_over pulse that makes the scoreboard latch high_score and clear score.
- Sits between the collision/food detection logic and the scoreboard.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/game_flow_ctrl_if.sv | 46 ++++
 rtl/game_flow_ctrl_respawn_timer.sv | 46 ++++
 rtl/game_flow_ctrl.sv | 137 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared encodings for the snake design: game state codes (also the value of
// the controller's `state` output) and fruit classes carried with food events.
// Used by the game flow controller, the scoreboard and the food logic.
// -----------------------------------------------------------------------------
package snake_pkg;

   // Game state encodings (legacy-compatible 2-bit codes)
   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_PLAYING = 2'b01;
   localparam logic [1:0] ST_RESPAWN = 2'b10;
   localparam logic [1:0] ST_OVER    = 2'b11;

   // Fruit classes qualifying a food_eaten pulse
   localparam logic [1:0] FRUIT_PLAIN  = 2'b00;
   localparam logic [1:0] FRUIT_GROW   = 2'b01;
   localparam logic [1:0] FRUIT_SHRINK = 2'b10;
   localparam logic [1:0] FRUIT_LIFE   = 2'b11;

   function automatic logic is_life_fruit(input logic [1:0] fruit);
      return fruit == FRUIT_LIFE;
   endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl_if
// Bundle between the collision/food detectors (master side) and the game flow
// controller (slave side), including the controller's outputs towards the
// scoreboard and snake motion logic.
//
// Signalling: there is no valid/ready handshake. Every event (collision,
// food_eaten, score_food, game_over) is a self-qualifying single-cycle pulse
// that the receiver must accept in the cycle it is high; fruit_type is only
// meaningful while food_eaten is high, score_fruit while score_food is high.
//
//   start_btn   : synchronised start button level (master -> ctrl)
//   collision   : 1-cycle pulse, snake hit wall/self (master -> ctrl)
//   food_eaten  : 1-cycle pulse from the food detector (master -> ctrl)
//   fruit_type  : fruit class of food_eaten (master -> ctrl)
//   state       : game state code (ctrl -> master)
//   lives       : remaining lives (ctrl -> master)
//   play_enable : snake motion enable, high only while playing
//   score_food  : gated food pulse to the scoreboard
//   score_fruit : fruit class accompanying score_food
//   game_over   : 1-cycle pulse to the scoreboard
// -----------------------------------------------------------------------------
interface game_flow_ctrl_if #(
   parameter int LIVES_W = 3
);
   logic               start_btn;
   logic               collision;
   logic               food_eaten;
   logic [1:0]         fruit_type;
   logic [1:0]         state;
   logic [LIVES_W-1:0] lives;
   logic               play_enable;
   logic               score_food;
   logic [1:0]         score_fruit;
   logic               game_over;

   modport master (
      output start_btn, collision, food_eaten, fruit_type,
      input  state, lives, play_enable, score_food, score_fruit, game_over
   );

   modport slave (
      input  start_btn, collision, food_eaten, fruit_type,
      output state, lives, play_enable, score_food, score_fruit, game_over
   );
endinterface

// File: rtl/game_flow_ctrl_respawn_timer.sv
// -----------------------------------------------------------------------------
// respawn_timer
// Down-counter timing the RESPAWN phase. load_i presets the count to
// RESPAWN_CYCLES-1; en_i decrements it while non-zero. done_o is high when the
// count has reached zero, so load followed by RESPAWN_CYCLES-1 decrements
// gives exactly RESPAWN_CYCLES cycles of occupancy in the caller's state.
//
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load_i     : preset count to RESPAWN_CYCLES-1 (wins over en_i)
//   en_i       : decrement enable
//   done_o     : count == 0
// -----------------------------------------------------------------------------
module respawn_timer #(
   parameter int RESPAWN_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic en_i,
   output logic done_o
);
   localparam int CNT_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RESPAWN_CYCLES - 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = LOAD_VAL;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// game_flow_ctrl
// Top-level game sequencer: owns the game state (idle/playing/respawn/over)
// and the lives count, gates food events into the scoreboard and issues the
// single-cycle game_over pulse. All outputs are registered.
//
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : game_flow_ctrl_if.slave (detector inputs, scoreboard/motion
//             outputs; state output doubles as the FSM debug view)
// -----------------------------------------------------------------------------
module game_flow_ctrl
   import snake_pkg::*;
#(
   parameter int INIT_LIVES     = 3,
   parameter int MAX_LIVES      = 7,
   parameter int LIVES_W        = 3,
   parameter int RESPAWN_CYCLES = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   game_flow_ctrl_if.slave bus
);
   localparam logic [LIVES_W-1:0] INIT_L = LIVES_W'(INIT_LIVES);
   localparam logic [LIVES_W-1:0] MAX_L  = LIVES_W'(MAX_LIVES);
   localparam logic [LIVES_W-1:0] ONE_L  = LIVES_W'(1);

   logic [1:0]         state_q, state_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic               play_en_q, play_en_d;
   logic               score_food_q, score_food_d;
   logic [1:0]         score_fruit_q, score_fruit_d;
   logic               game_over_q, game_over_d;
   logic               start_prev_q;
   logic               start_edge;
   logic               timer_load, timer_en, timer_done;

   assign start_edge = bus.start_btn & ~start_prev_q;

   respawn_timer #(.RESPAWN_CYCLES(RESPAWN_CYCLES)) u_respawn_timer (
      .clk    (clk),
      .rst_n  (reset_n),
      .load_i (timer_load),
      .en_i   (timer_en),
      .done_o (timer_done)
   );

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      score_food_d  = 1'b0;
      score_fruit_d = score_fruit_q;   // holds last fruit between pulses
      game_over_d   = 1'b0;            // only ever high for one cycle
      timer_load    = 1'b0;
      timer_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_edge) begin
               state_d = ST_PLAYING;
               lives_d = INIT_L;
            end
         end

         ST_PLAYING: begin
            // Collision has priority: a coincident food event is dropped.
            if (bus.collision) begin
               if (lives_q > ONE_L) begin
                  lives_d    = lives_q - ONE_L;
                  timer_load = 1'b1;
                  state_d    = ST_RESPAWN;
               end else begin
                  lives_d     = '0;
                  state_d     = ST_OVER;
                  game_over_d = 1'b1;   // lands in the first OVER cycle
               end
            end else if (bus.food_eaten) begin
               score_food_d  = 1'b1;
               score_fruit_d = bus.fruit_type;
               if (is_life_fruit(bus.fruit_type)) begin
                  lives_d = (lives_q >= MAX_L) ? MAX_L : lives_q + ONE_L;
               end
            end
         end

         ST_RESPAWN: begin
            if (timer_done) begin
               state_d = ST_PLAYING;
            end else begin
               timer_en = 1'b1;
            end
         end

         ST_OVER: begin
            if (start_edge) begin
               state_d = ST_PLAYING;
               lives_d = INIT_L;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      play_en_d = (state_d == ST_PLAYING);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         lives_q       <= INIT_L;
         play_en_q     <= 1'b0;
         score_food_q  <= 1'b0;
         score_fruit_q <= FRUIT_PLAIN;
         game_over_q   <= 1'b0;
         // Reset to 1 so a button held through reset is not seen as a press.
         start_prev_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         play_en_q     <= play_en_d;
         score_food_q  <= score_food_d;
         score_fruit_q <= score_fruit_d;
         game_over_q   <= game_over_d;
         start_prev_q  <= bus.start_btn;
      end
   end

   assign bus.state       = state_q;
   assign bus.lives       = lives_q;
   assign bus.play_enable = play_en_q;
   assign bus.score_food  = score_food_q;
   assign bus.score_fruit = score_fruit_q;
   assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_flow_ctrl
// Self-checking bench for game_flow_ctrl. Expected fruit codes are queued when
// a food pulse is driven in PLAYING and popped by a monitor when score_food
// appears. A small scoreboard stand-in (score/high_score) follows the DUT's
// score_food and game_over pulses.
// -----------------------------------------------------------------------------
module tb_game_flow_ctrl;
   import snake_pkg::*;

   localparam int LIVES_W = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [1:0] exp_q[$];
   int sb_score = 0;
   int sb_high = 0;

   game_flow_ctrl_if #(.LIVES_W(LIVES_W)) bus ();

   game_flow_ctrl #(
      .INIT_LIVES     (3),
      .MAX_LIVES      (7),
      .LIVES_W        (LIVES_W),
      .RESPAWN_CYCLES (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset_n) begin
         sb_score = 0;
      end else begin
         vec_cnt++;
         if (bus.score_food && bus.game_over) begin
            err_cnt++;
            $display("FAIL overlap: score_food=%0b game_over=%0b both high", bus.score_food, bus.game_over);
         end
         if (bus.score_food) begin
            vec_cnt++;
            if (exp_q.size() == 0) begin
               err_cnt++;
               $display("FAIL unexpected_score_food: got fruit %0b, expected no pulse", bus.score_fruit);
            end else begin
               logic [1:0] exp_f;
               exp_f = exp_q.pop_front();
               if (bus.score_fruit !== exp_f) begin
                  err_cnt++;
                  $display("FAIL score_fruit: got %0b expected %0b", bus.score_fruit, exp_f);
               end
            end
            sb_score++;
         end
         if (bus.game_over) begin
            if (sb_score > sb_high) sb_high = sb_score;
            sb_score = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start_btn  = 1'b0;
      bus.collision  = 1'b0;
      bus.food_eaten = 1'b0;
      bus.fruit_type = FRUIT_PLAIN;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic press_start();
      bus.start_btn = 1'b0;
      tick();
      bus.start_btn = 1'b1;
      tick();
      bus.start_btn = 1'b0;
   endtask

   task automatic pulse_collision();
      bus.collision = 1'b1;
      tick();
      bus.collision = 1'b0;
   endtask

   task automatic wait_playing();
      for (int i = 0; i < 64; i++) begin
         if (bus.state == ST_PLAYING) break;
         tick();
      end
      vec_cnt++;
      if (bus.state !== ST_PLAYING) begin
         err_cnt++;
         $display("FAIL wait_playing: state %0b expected %0b within 64 cycles", bus.state, ST_PLAYING);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      bus.start_btn = 1'b1;
      reset_n = 1'b0;
      #12;
      vec_cnt++;
      if (bus.state !== ST_IDLE || bus.lives !== 3'd3 || bus.play_enable !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_state: state=%0b lives=%0d play=%0b expected 00/3/0", bus.state, bus.lives, bus.play_enable);
      end
      vec_cnt++;
      if (bus.score_food !== 1'b0 || bus.score_fruit !== 2'b00 || bus.game_over !== 1'b0) begin
         err_cnt++;
         $display("FAIL reset_outputs: food=%0b fruit=%0b over=%0b expected 0/00/0", bus.score_food, bus.score_fruit, bus.game_over);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) tick();
      vec_cnt++;
      if (bus.state !== ST_IDLE || bus.play_enable !== 1'b0) begin
         err_cnt++;
         $display("FAIL held_start: state=%0b play=%0b expected 00/0", bus.state, bus.play_enable);
      end
      bus.start_btn = 1'b0;
      tick();
      bus.start_btn = 1'b1;
      tick();
      bus.start_btn = 1'b0;
      vec_cnt++;
      if (bus.state !== ST_PLAYING || bus.lives !== 3'd3 || bus.play_enable !== 1'b1) begin
         err_cnt++;
         $display("FAIL start: state=%0b lives=%0d play=%0b expected 01/3/1", bus.state, bus.lives, bus.play_enable);
      end
   endtask

   task automatic test_food();
      logic [1:0] fruits[3];
      logic [2:0] exp_l;
      fruits[0] = FRUIT_GROW;
      fruits[1] = FRUIT_PLAIN;
      fruits[2] = FRUIT_SHRINK;
      for (int i = 0; i < 3; i++) begin
         bus.food_eaten = 1'b1;
         bus.fruit_type = fruits[i];
         exp_q.push_back(fruits[i]);
         tick();
         bus.food_eaten = 1'b0;
         vec_cnt++;
         if (bus.score_food !== 1'b1 || bus.score_fruit !== fruits[i]) begin
            err_cnt++;
            $display("FAIL food_latency: food=%0b fruit=%0b expected 1/%0b", bus.score_food, bus.score_fruit, fruits[i]);
         end
         tick();
         vec_cnt++;
         if (bus.score_food !== 1'b0 || bus.score_fruit !== fruits[i]) begin
            err_cnt++;
            $display("FAIL food_single: food=%0b fruit=%0b expected 0/%0b", bus.score_food, bus.score_fruit, fruits[i]);
         end
      end
      exp_l = 3'd3;
      for (int i = 0; i < 5; i++) begin
         bus.food_eaten = 1'b1;
         bus.fruit_type = FRUIT_LIFE;
         exp_q.push_back(FRUIT_LIFE);
         tick();
         bus.food_eaten = 1'b0;
         if (exp_l < 3'd7) exp_l = exp_l + 3'd1;
         vec_cnt++;
         if (bus.lives !== exp_l || bus.score_food !== 1'b1) begin
            err_cnt++;
            $display("FAIL life_fruit: lives=%0d food=%0b expected %0d/1", bus.lives, bus.score_food, exp_l);
         end
      end
      tick();
   endtask

   task automatic test_respawn();
      int cnt;
      apply_reset();
      press_start();
      pulse_collision();
      vec_cnt++;
      if (bus.lives !== 3'd2 || bus.state !== ST_RESPAWN || bus.play_enable !== 1'b0) begin
         err_cnt++;
         $display("FAIL respawn_enter: lives=%0d state=%0b play=%0b expected 2/10/0", bus.lives, bus.state, bus.play_enable);
      end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         bus.food_eaten = (i == 0) || ($urandom_range(0, 1) == 1);
         bus.collision  = (i == 1) || ($urandom_range(0, 3) == 0);
         bus.fruit_type = FRUIT_LIFE;
         tick();
         vec_cnt++;
         if (bus.score_food !== 1'b0 || bus.lives !== 3'd2) begin
            err_cnt++;
            $display("FAIL respawn_ignore: food=%0b lives=%0d expected 0/2", bus.score_food, bus.lives);
         end
         if (bus.state !== ST_RESPAWN) break;
         cnt++;
      end
      clear_inputs();
      vec_cnt++;
      if (cnt != 16 || bus.state !== ST_PLAYING || bus.play_enable !== 1'b1) begin
         err_cnt++;
         $display("FAIL respawn_len: cycles=%0d state=%0b play=%0b expected 16/01/1", cnt, bus.state, bus.play_enable);
      end
   endtask

   task automatic test_game_over();
      pulse_collision();
      wait_playing();
      pulse_collision();
      vec_cnt++;
      if (bus.state !== ST_OVER || bus.lives !== 3'd0 || bus.game_over !== 1'b1 || bus.play_enable !== 1'b0) begin
         err_cnt++;
         $display("FAIL over_enter: state=%0b lives=%0d over=%0b play=%0b expected 11/0/1/0", bus.state, bus.lives, bus.game_over, bus.play_enable);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         vec_cnt++;
         if (bus.state !== ST_OVER || bus.game_over !== 1'b0) begin
            err_cnt++;
            $display("FAIL over_pulse: state=%0b over=%0b expected 11/0", bus.state, bus.game_over);
         end
      end
      press_start();
      vec_cnt++;
      if (bus.state !== ST_PLAYING || bus.lives !== 3'd3) begin
         err_cnt++;
         $display("FAIL over_restart: state=%0b lives=%0d expected 01/3", bus.state, bus.lives);
      end
   endtask

   task automatic test_collide_and_food();
      pulse_collision();
      wait_playing();
      bus.collision  = 1'b1;
      bus.food_eaten = 1'b1;
      bus.fruit_type = FRUIT_LIFE;
      tick();
      clear_inputs();
      vec_cnt++;
      if (bus.lives !== 3'd1 || bus.state !== ST_RESPAWN || bus.score_food !== 1'b0) begin
         err_cnt++;
         $display("FAIL collide_food: lives=%0d state=%0b food=%0b expected 1/10/0", bus.lives, bus.state, bus.score_food);
      end
      wait_playing();
      // start press landing in the game_over cycle
      pulse_collision();
      vec_cnt++;
      if (bus.game_over !== 1'b1 || bus.state !== ST_OVER) begin
         err_cnt++;
         $display("FAIL over_coincide_pre: over=%0b state=%0b expected 1/11", bus.game_over, bus.state);
      end
      bus.start_btn = 1'b1;
      tick();
      bus.start_btn = 1'b0;
      vec_cnt++;
      if (bus.state !== ST_PLAYING || bus.lives !== 3'd3 || bus.game_over !== 1'b0) begin
         err_cnt++;
         $display("FAIL over_coincide: state=%0b lives=%0d over=%0b expected 01/3/0", bus.state, bus.lives, bus.game_over);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] f;
      logic [2:0] exp_l;
      exp_l = 3'd3;
      for (int i = 0; i < 8; i++) begin
         f = 2'($urandom_range(0, 3));
         if (i >= 4) f = FRUIT_LIFE;
         bus.food_eaten = 1'b1;
         bus.fruit_type = f;
         exp_q.push_back(f);
         if (f == FRUIT_LIFE && exp_l < 3'd7) exp_l = exp_l + 3'd1;
         tick();
         vec_cnt++;
         if (bus.score_food !== 1'b1 || bus.lives !== exp_l) begin
            err_cnt++;
            $display("FAIL back_to_back: food=%0b lives=%0d expected 1/%0d", bus.score_food, bus.lives, exp_l);
         end
      end
      clear_inputs();
      tick();
      vec_cnt++;
      if (bus.score_food !== 1'b0 || bus.lives !== exp_l) begin
         err_cnt++;
         $display("FAIL back_to_back_end: food=%0b lives=%0d expected 0/%0d", bus.score_food, bus.lives, exp_l);
      end
   endtask

   task automatic test_reset_mid_respawn();
      pulse_collision();
      repeat (3) tick();
      #2;
      reset_n = 1'b0;
      #1;
      vec_cnt++;
      if (bus.state !== ST_IDLE || bus.lives !== 3'd3 || bus.play_enable !== 1'b0 ||
          bus.score_food !== 1'b0 || bus.game_over !== 1'b0) begin
         err_cnt++;
         $display("FAIL async_reset: state=%0b lives=%0d play=%0b food=%0b over=%0b expected 00/3/0/0/0",
                  bus.state, bus.lives, bus.play_enable, bus.score_food, bus.game_over);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_scoreboard_link();
      sb_high = 0;
      press_start();
      for (int i = 0; i < 30; i++) begin
         bus.food_eaten = 1'b1;
         bus.fruit_type = FRUIT_PLAIN;
         exp_q.push_back(FRUIT_PLAIN);
         tick();
      end
      clear_inputs();
      tick();
      pulse_collision();
      wait_playing();
      pulse_collision();
      wait_playing();
      pulse_collision();
      tick();
      vec_cnt++;
      if (sb_high != 30 || sb_score != 0) begin
         err_cnt++;
         $display("FAIL scoreboard_link: high=%0d score=%0d expected 30/0", sb_high, sb_score);
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_food();
      test_respawn();
      test_game_over();
      test_collide_and_food();
      test_back_to_back();
      test_reset_mid_respawn();
      test_scoreboard_link();
      vec_cnt++;
      if (exp_q.size() != 0) begin
         err_cnt++;
         $display("FAIL drain: %0d expected food events never seen, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
